// File: rtl/seq_alu_if.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu_if
// Brief    : Request/response bundle between the control unit and seq_alu.
// Revision : 1.0 - initial release
// ============================================================================
interface seq_alu_if #(
    parameter int WIDTH = 32
) ();
    logic             start;
    logic [4:0]       op;
    logic [WIDTH-1:0] ra;
    logic [WIDTH-1:0] rb;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result_hi;
    logic [WIDTH-1:0] result_lo;
    logic             div_by_zero;
    logic             illegal_op;

    modport master (
        output start, op, ra, rb,
        input  busy, done, result_hi, result_lo, div_by_zero, illegal_op
    );

    modport slave (
        input  start, op, ra, rb,
        output busy, done, result_hi, result_lo, div_by_zero, illegal_op
    );
endinterface
`default_nettype wire

// File: rtl/seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : seq_alu
// Brief    : Multi-cycle ALU: 1-cycle logic/add/shift, Booth MUL and restoring
//            DIV iterating one bit per clock. Define SEQ_ALU_DIV_EN for DIV.
// Revision : 1.0 - initial release
// ============================================================================
module seq_alu #(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  wire logic  clock,
    input  wire logic  clear,
    seq_alu_if.slave   bus
);

    localparam logic [4:0] c_OP_ADD  = 5'b00011;
    localparam logic [4:0] c_OP_SUB  = 5'b00100;
    localparam logic [4:0] c_OP_AND  = 5'b00101;
    localparam logic [4:0] c_OP_OR   = 5'b00110;
    localparam logic [4:0] c_OP_ROR  = 5'b00111;
    localparam logic [4:0] c_OP_ROL  = 5'b01000;
    localparam logic [4:0] c_OP_SHR  = 5'b01001;
    localparam logic [4:0] c_OP_SHRA = 5'b01010;
    localparam logic [4:0] c_OP_SHL  = 5'b01011;
    localparam logic [4:0] c_OP_ADDI = 5'b01100;
    localparam logic [4:0] c_OP_ANDI = 5'b01101;
    localparam logic [4:0] c_OP_ORI  = 5'b01110;
    localparam logic [4:0] c_OP_MUL  = 5'b10000;
    localparam logic [4:0] c_OP_NEG  = 5'b10001;
    localparam logic [4:0] c_OP_NOT  = 5'b10010;
    localparam logic [4:0] c_OP_SHLA = 5'b10011;
`ifdef SEQ_ALU_DIV_EN
    localparam logic [4:0] c_OP_DIV  = 5'b01111;
`endif
    localparam logic [SHW-1:0] c_CNT_LAST = SHW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2
    } state_t;

    state_t           r_state;
    logic [SHW-1:0]   r_cnt;
    logic             r_busy;
    logic             r_done;
    logic             r_ill;
    logic [WIDTH-1:0] r_hi;
    logic [WIDTH-1:0] r_lo;

    // Booth accumulator carries one guard bit so that subtracting MIN cannot overflow.
    logic [WIDTH:0]   r_acc;
    logic [WIDTH:0]   r_mcand;
    logic [WIDTH-1:0] r_mq;
    logic             r_q1;
    logic [WIDTH:0]   w_booth_sum;
    logic [WIDTH:0]   w_acc_n;
    logic [WIDTH-1:0] w_mq_n;

    logic [SHW-1:0]   w_amt;
    logic [SHW-1:0]   w_amt_inv;
    logic [WIDTH-1:0] w_lo;
    logic             w_illegal;

    always_comb begin
        w_booth_sum = r_acc;
        case ({r_mq[0], r_q1})
            2'b01:   w_booth_sum = r_acc + r_mcand;
            2'b10:   w_booth_sum = r_acc - r_mcand;
            default: w_booth_sum = r_acc;
        endcase
    end

    assign w_acc_n = {w_booth_sum[WIDTH], w_booth_sum[WIDTH:1]};
    assign w_mq_n  = {w_booth_sum[0], r_mq[WIDTH-1:1]};

`ifdef SEQ_ALU_DIV_EN
    logic             r_dbz;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_dvs;
    logic             r_qneg;
    logic             r_rneg;
    logic [WIDTH:0]   w_div_shift;
    logic             w_div_fits;
    logic [WIDTH-1:0] w_rem_n;
    logic [WIDTH-1:0] w_quo_n;
    logic [WIDTH-1:0] w_ra_abs;
    logic [WIDTH-1:0] w_rb_abs;

    // Magnitudes are divided unsigned; |MIN| is exactly representable as unsigned.
    assign w_ra_abs    = bus.ra[WIDTH-1] ? -bus.ra : bus.ra;
    assign w_rb_abs    = bus.rb[WIDTH-1] ? -bus.rb : bus.rb;
    assign w_div_shift = {r_rem, r_quo[WIDTH-1]};
    assign w_div_fits  = (w_div_shift >= {1'b0, r_dvs});
    assign w_rem_n     = w_div_fits ? (w_div_shift[WIDTH-1:0] - r_dvs) : w_div_shift[WIDTH-1:0];
    assign w_quo_n     = {r_quo[WIDTH-2:0], w_div_fits};
    assign bus.div_by_zero = r_dbz;
`else
    assign bus.div_by_zero = 1'b0;
`endif

    // Rotates use the complementary amount modulo WIDTH, so amount 0 stays exact.
    assign w_amt     = bus.rb[SHW-1:0];
    assign w_amt_inv = -w_amt;

    always_comb begin
        w_lo      = '0;
        w_illegal = 1'b0;
        case (bus.op)
            c_OP_ADD, c_OP_ADDI: w_lo = bus.ra + bus.rb;
            c_OP_SUB:            w_lo = bus.ra - bus.rb;
            c_OP_AND, c_OP_ANDI: w_lo = bus.ra & bus.rb;
            c_OP_OR,  c_OP_ORI:  w_lo = bus.ra | bus.rb;
            c_OP_ROR:            w_lo = (bus.ra >> w_amt) | (bus.ra << w_amt_inv);
            c_OP_ROL:            w_lo = (bus.ra << w_amt) | (bus.ra >> w_amt_inv);
            c_OP_SHR:            w_lo = bus.ra >> w_amt;
            c_OP_SHRA:           w_lo = $signed(bus.ra) >>> w_amt;
            c_OP_SHL, c_OP_SHLA: w_lo = bus.ra << w_amt;
            c_OP_NEG:            w_lo = -bus.rb;
            c_OP_NOT:            w_lo = ~bus.rb;
            c_OP_MUL:            w_lo = '0;
`ifdef SEQ_ALU_DIV_EN
            c_OP_DIV:            w_lo = '0;
`endif
            default:             w_illegal = 1'b1;
        endcase
    end

    always_ff @(posedge clock or negedge clear) begin
        if (!clear) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_ill   <= 1'b0;
            r_hi    <= '0;
            r_lo    <= '0;
            r_acc   <= '0;
            r_mcand <= '0;
            r_mq    <= '0;
            r_q1    <= 1'b0;
`ifdef SEQ_ALU_DIV_EN
            r_dbz   <= 1'b0;
            r_rem   <= '0;
            r_quo   <= '0;
            r_dvs   <= '0;
            r_qneg  <= 1'b0;
            r_rneg  <= 1'b0;
`endif
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_ill <= 1'b0;
                        r_cnt <= '0;
`ifdef SEQ_ALU_DIV_EN
                        r_dbz <= 1'b0;
`endif
                        if (bus.op == c_OP_MUL) begin
                            r_state <= S_MUL;
                            r_busy  <= 1'b1;
                            r_acc   <= '0;
                            r_mcand <= {bus.ra[WIDTH-1], bus.ra};
                            r_mq    <= bus.rb;
                            r_q1    <= 1'b0;
                        end
`ifdef SEQ_ALU_DIV_EN
                        else if (bus.op == c_OP_DIV && bus.rb != '0) begin
                            r_state <= S_DIV;
                            r_busy  <= 1'b1;
                            r_rem   <= '0;
                            r_quo   <= w_ra_abs;
                            r_dvs   <= w_rb_abs;
                            r_qneg  <= bus.ra[WIDTH-1] ^ bus.rb[WIDTH-1];
                            r_rneg  <= bus.ra[WIDTH-1];
                        end else if (bus.op == c_OP_DIV) begin
                            r_lo   <= '1;
                            r_hi   <= bus.ra;
                            r_dbz  <= 1'b1;
                            r_done <= 1'b1;
                        end
`endif
                        else begin
                            r_lo   <= w_lo;
                            r_hi   <= '0;
                            r_ill  <= w_illegal;
                            r_done <= 1'b1;
                        end
                    end
                end
                S_MUL: begin
                    r_acc <= w_acc_n;
                    r_mq  <= w_mq_n;
                    r_q1  <= r_mq[0];
                    if (r_cnt == c_CNT_LAST) begin
                        r_hi    <= w_acc_n[WIDTH-1:0];
                        r_lo    <= w_mq_n;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`ifdef SEQ_ALU_DIV_EN
                S_DIV: begin
                    r_rem <= w_rem_n;
                    r_quo <= w_quo_n;
                    if (r_cnt == c_CNT_LAST) begin
                        r_lo    <= r_qneg ? -w_quo_n : w_quo_n;
                        r_hi    <= r_rneg ? -w_rem_n : w_rem_n;
                        r_done  <= 1'b1;
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
`endif
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.busy      = r_busy;
    assign bus.done      = r_done;
    assign bus.result_hi = r_hi;
    assign bus.result_lo = r_lo;
    assign bus.illegal_op = r_ill;

endmodule
`default_nettype wire

// File: tb/tb_seq_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_alu
// Brief    : Directed vector table plus busy-overlap and reset-abort sequences.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_alu;

    localparam int W = 32;

    localparam logic [4:0] OP_ADD  = 5'b00011;
    localparam logic [4:0] OP_SUB  = 5'b00100;
    localparam logic [4:0] OP_AND  = 5'b00101;
    localparam logic [4:0] OP_ORI  = 5'b01110;
    localparam logic [4:0] OP_ROR  = 5'b00111;
    localparam logic [4:0] OP_ROL  = 5'b01000;
    localparam logic [4:0] OP_SHR  = 5'b01001;
    localparam logic [4:0] OP_SHRA = 5'b01010;
    localparam logic [4:0] OP_SHLA = 5'b10011;
    localparam logic [4:0] OP_NEG  = 5'b10001;
    localparam logic [4:0] OP_NOT  = 5'b10010;
    localparam logic [4:0] OP_MUL  = 5'b10000;
    localparam logic [4:0] OP_DIV  = 5'b01111;
    localparam logic [4:0] OP_BAD  = 5'b11111;

    typedef struct {
        logic [4:0]   op;
        logic [W-1:0] ra;
        logic [W-1:0] rb;
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dbz;
        logic         ill;
        int           lat;
    } vec_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   n_tests = 0;
    int   n_fail  = 0;
    vec_t vecs[$];

    seq_alu_if #(.WIDTH(W)) bus ();

    seq_alu #(.WIDTH(W)) dut (
        .clock (clk),
        .clear (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] op, input logic [W-1:0] ra, input logic [W-1:0] rb,
                       input logic [W-1:0] hi, input logic [W-1:0] lo,
                       input logic dbz, input logic ill, input int lat);
        vec_t v;
        v.op = op; v.ra = ra; v.rb = rb; v.hi = hi; v.lo = lo;
        v.dbz = dbz; v.ill = ill; v.lat = lat;
        vecs.push_back(v);
    endtask

    // Latency is counted in rising edges after the accepting edge.
    task automatic run_vec(input int idx, input vec_t v);
        int edges = 0;
        int busy_cnt = 0;
        @(negedge clk);
        bus.start = 1'b1; bus.op = v.op; bus.ra = v.ra; bus.rb = v.rb;
        @(negedge clk);
        bus.start = 1'b0; bus.op = 5'b00000; bus.ra = 32'hA5A5A5A5; bus.rb = 32'h5A5A5A5A;
        while (bus.done !== 1'b1 && edges < 100) begin
            if (bus.busy === 1'b1) busy_cnt++;
            @(negedge clk);
            edges++;
        end
        check($sformatf("v%0d_done", idx), {31'b0, bus.done}, 32'd1);
        check($sformatf("v%0d_latency", idx), W'(edges), W'(v.lat));
        check($sformatf("v%0d_busy_cycles", idx), W'(busy_cnt), W'(v.lat));
        check($sformatf("v%0d_hi", idx), bus.result_hi, v.hi);
        check($sformatf("v%0d_lo", idx), bus.result_lo, v.lo);
        check($sformatf("v%0d_dbz", idx), {31'b0, bus.div_by_zero}, {31'b0, v.dbz});
        check($sformatf("v%0d_ill", idx), {31'b0, bus.illegal_op}, {31'b0, v.ill});
        @(negedge clk);
        check($sformatf("v%0d_done_pulse", idx), {31'b0, bus.done}, 32'd0);
        check($sformatf("v%0d_hi_hold", idx), bus.result_hi, v.hi);
    endtask

    initial begin
        int edges;
        int dones;
        bus.start = 1'b0; bus.op = 5'b0; bus.ra = '0; bus.rb = '0;

        add(OP_ADD,  32'd1,        32'd1,        32'h0, 32'h00000002, 1'b0, 1'b0, 0);
        add(OP_SUB,  32'd5,        32'd7,        32'h0, 32'hFFFFFFFE, 1'b0, 1'b0, 0);
        add(OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0, 32'hF000F000, 1'b0, 1'b0, 0);
        add(OP_ORI,  32'h0F0F0000, 32'h000000F0, 32'h0, 32'h0F0F00F0, 1'b0, 1'b0, 0);
        add(OP_ROR,  32'h12345678, 32'h00000024, 32'h0, 32'h81234567, 1'b0, 1'b0, 0);
        add(OP_ROL,  32'h12345678, 32'h00000004, 32'h0, 32'h23456781, 1'b0, 1'b0, 0);
        add(OP_SHR,  32'h80000000, 32'h00000004, 32'h0, 32'h08000000, 1'b0, 1'b0, 0);
        add(OP_SHRA, 32'h80000000, 32'h00000004, 32'h0, 32'hF8000000, 1'b0, 1'b0, 0);
        add(OP_SHLA, 32'h00000001, 32'h0000003F, 32'h0, 32'h80000000, 1'b0, 1'b0, 0);
        add(OP_NEG,  32'h0,        32'd5,        32'h0, 32'hFFFFFFFB, 1'b0, 1'b0, 0);
        add(OP_NOT,  32'h0,        32'h0F0F0F0F, 32'h0, 32'hF0F0F0F0, 1'b0, 1'b0, 0);
        add(OP_BAD,  32'h1234,     32'h5678,     32'h0, 32'h0,        1'b0, 1'b1, 0);
        add(OP_MUL,  32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 1'b0, W);
        add(OP_MUL,  32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 1'b0, 1'b0, W);
        add(OP_MUL,  32'h7FFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000001, 1'b0, 1'b0, W);
        add(OP_MUL,  32'h12345678, 32'h00000010, 32'h00000001, 32'h23456780, 1'b0, 1'b0, W);
`ifdef SEQ_ALU_DIV_EN
        add(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 1'b0, W);
        add(OP_DIV,  32'd5,        32'd0,        32'h00000005, 32'hFFFFFFFF, 1'b1, 1'b0, 0);
        add(OP_ADD,  32'd1,        32'd1,        32'h0,        32'h00000002, 1'b0, 1'b0, 0);
        add(OP_DIV,  32'h80000000, 32'hFFFFFFFF, 32'h0,        32'h80000000, 1'b0, 1'b0, W);
        add(OP_DIV,  32'd7,        32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 1'b0, 1'b0, W);
`else
        add(OP_DIV,  32'hFFFFFFF9, 32'd2,        32'h0, 32'h0,        1'b0, 1'b1, 0);
        add(OP_DIV,  32'd5,        32'd0,        32'h0, 32'h0,        1'b0, 1'b1, 0);
        add(OP_ADD,  32'd1,        32'd1,        32'h0, 32'h00000002, 1'b0, 1'b0, 0);
`endif

        repeat (3) @(negedge clk);
        check("reset_busy", {31'b0, bus.busy}, 32'd0);
        check("reset_done", {31'b0, bus.done}, 32'd0);
        check("reset_hi", bus.result_hi, 32'h0);
        check("reset_lo", bus.result_lo, 32'h0);
        check("reset_flags", {30'b0, bus.div_by_zero, bus.illegal_op}, 32'd0);
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++) run_vec(i, vecs[i]);

        // MUL with a start pulse while busy, then a new op accepted on the done cycle
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MUL; bus.ra = 32'hFFFFFFFD; bus.rb = 32'd7;
        @(negedge clk);
        bus.start = 1'b0;
        edges = 0;
        while (bus.done !== 1'b1 && edges < 100) begin
            if (edges == 5) begin
                bus.start = 1'b1; bus.op = OP_ADD; bus.ra = 32'd1; bus.rb = 32'd1;
            end else begin
                bus.start = 1'b0;
            end
            @(negedge clk);
            edges++;
        end
        check("ovl_done", {31'b0, bus.done}, 32'd1);
        check("ovl_latency", W'(edges), W'(W));
        check("ovl_hi", bus.result_hi, 32'hFFFFFFFF);
        check("ovl_lo", bus.result_lo, 32'hFFFFFFEB);
        bus.start = 1'b1; bus.op = OP_ADD; bus.ra = 32'd2; bus.rb = 32'd3;
        @(negedge clk);
        bus.start = 1'b0;
        check("b2b_done", {31'b0, bus.done}, 32'd1);
        check("b2b_lo", bus.result_lo, 32'd5);
        check("b2b_hi", bus.result_hi, 32'd0);

        // Reset in the middle of a MUL
        @(negedge clk);
        bus.start = 1'b1; bus.op = OP_MUL; bus.ra = 32'h1234; bus.rb = 32'h5678;
        @(negedge clk);
        bus.start = 1'b0;
        repeat (9) @(negedge clk);
        check("abort_busy_before", {31'b0, bus.busy}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("abort_busy", {31'b0, bus.busy}, 32'd0);
        check("abort_done", {31'b0, bus.done}, 32'd0);
        check("abort_hi", bus.result_hi, 32'h0);
        check("abort_lo", bus.result_lo, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        dones = 0;
        repeat (40) begin
            @(negedge clk);
            if (bus.done === 1'b1) dones++;
        end
        check("abort_no_done", W'(dones), 32'd0);
        begin
            vec_t v;
            v.op = OP_ADD; v.ra = 32'd4; v.rb = 32'd5; v.hi = 32'h0; v.lo = 32'd9;
            v.dbz = 1'b0; v.ill = 1'b0; v.lat = 0;
            run_vec(99, v);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
